// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg: shared state encoding and limits for the clock-divider scheduler
package clk_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: prescaler counter with terminal-count decode and registered half-period flag
// Ports: clk/rst; en = counter runs next cycle; clear = force counter to 0; div = active divisor;
//        tc = counter at div-1; half = registered (running && counter >= div>>1)
module clk_div_core #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             tc,
  output logic             half
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_half;
  assign tc        = r_cnt == div - CNT_W'(1);
  assign w_cnt_nxt = (!en || clear || tc) ? '0 : r_cnt + CNT_W'(1);
  assign half      = r_half;
  // Divisor changes only coincide with a zero next count, and 0 < div>>1 for any
  // legal divisor, so comparing against the current divisor is always correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_half <= en && (w_cnt_nxt >= (div >> 1));
    end
  end
endmodule

// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler: runtime-programmable prescaler with handshake config, start/stop and one-shot
// Ports: clk/rst; cfg_valid/cfg_ready/cfg_div/cfg_oneshot config handshake; cfg_err illegal-divisor pulse;
//        start/stop run control; tick period strobe; slow_clk square wave; busy; tick_count ticks since start
module clk_div_scheduler
  import clk_sched_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100000000,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  output logic              tick,
  output logic              slow_clk,
  output logic              busy,
  output logic [TCNT_W-1:0] tick_count
);
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_div, r_div_pend;
  logic              r_oneshot, r_oneshot_pend, r_cfg_err;
  logic [TCNT_W-1:0] r_tick_count;
  logic              w_tc, w_xfer, w_legal, w_end, w_apply, w_load, w_hold, w_start;
  assign cfg_ready  = r_state != PEND;
  assign busy       = r_state != IDLE;
  assign cfg_err    = r_cfg_err;
  assign tick_count = r_tick_count;
  assign w_legal    = cfg_div >= CNT_W'(MIN_DIV);
  assign w_xfer     = cfg_valid && cfg_ready;
  assign tick       = busy && w_tc && !stop;
  assign w_start    = r_state == IDLE && start && !stop;
  assign w_end      = busy && (stop || (tick && r_oneshot));
  // A pending config always lands when its period ends, whether by tick or by stop.
  assign w_apply    = r_state == PEND && (w_tc || stop);
  // Config accepted while idle, or while a run is ending, takes effect immediately.
  assign w_load     = w_xfer && w_legal && (r_state == IDLE || w_end);
  assign w_hold     = w_xfer && w_legal && r_state == RUN && !w_end;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (w_start ? RUN : IDLE) :
                  w_end             ? IDLE :
                  (r_state == RUN)  ? (w_hold ? PEND : RUN) :
                  w_tc              ? RUN : PEND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_div          <= CNT_W'(DEFAULT_DIV);
      r_oneshot      <= 1'b0;
      r_div_pend     <= '0;
      r_oneshot_pend <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_tick_count   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_div          <= w_apply ? r_div_pend : w_load ? cfg_div : r_div;
      r_oneshot      <= w_apply ? r_oneshot_pend : w_load ? cfg_oneshot : r_oneshot;
      r_div_pend     <= w_hold ? cfg_div : r_div_pend;
      r_oneshot_pend <= w_hold ? cfg_oneshot : r_oneshot_pend;
      r_cfg_err      <= w_xfer && !w_legal;
      r_tick_count   <= w_start ? '0 : r_tick_count + TCNT_W'(tick);
    end
  end
  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (w_state_nxt != IDLE),
    .clear (r_state == IDLE),
    .div   (r_div),
    .tc    (w_tc),
    .half  (slow_clk)
  );
endmodule

// File: tb/tb_clk_div_scheduler.sv
// tb_clk_div_scheduler: directed self-checking bench for clk_div_scheduler
module tb_clk_div_scheduler;
  localparam int CNT_W  = 27;
  localparam int TCNT_W = 16;
  logic              clk = 1'b0, rst = 1'b1;
  logic              cfg_valid = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready, cfg_err, tick, slow_clk, busy;
  logic [TCNT_W-1:0] tick_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  clk_div_scheduler #(.CNT_W(CNT_W), .DEFAULT_DIV(4), .TCNT_W(TCNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
    .cfg_oneshot(cfg_oneshot), .cfg_err(cfg_err), .start(start), .stop(stop), .tick(tick),
    .slow_clk(slow_clk), .busy(busy), .tick_count(tick_count)
  );
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    nxt();
    nxt();
    smp();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_slow", 32'(slow_clk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_tcnt", 32'(tick_count), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    rst = 1'b0;
    nxt();
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      smp();
      chk($sformatf("t1_tick_c%0d", c), 32'(tick), 32'(c % 4 == 0));
      chk($sformatf("t1_slow_c%0d", c), 32'(slow_clk), 32'(c % 4 == 3 || c % 4 == 0));
      chk($sformatf("t1_tcnt_c%0d", c), 32'(tick_count), 32'((c - 1) / 4));
      nxt();
    end
    smp();
    chk("t1_tcnt_end", 32'(tick_count), 3);
    chk("t1_busy", 32'(busy), 1);
    nxt();
    cfg_valid = 1'b1;
    cfg_div = 27'd6;
    cfg_oneshot = 1'b0;
    smp();
    chk("t2_ready_run", 32'(cfg_ready), 1);
    nxt();
    cfg_valid = 1'b0;
    for (int c = 15; c <= 28; c++) begin
      smp();
      chk($sformatf("t2_tick_c%0d", c), 32'(tick), 32'(c == 16 || c == 22 || c == 28));
      chk($sformatf("t2_ready_c%0d", c), 32'(cfg_ready), 32'(c > 16));
      nxt();
    end
    for (int i = 0; i < 5; i++) nxt();
    stop = 1'b1;
    smp();
    chk("t5_stop_tick", 32'(tick), 0);
    chk("t5_stop_busy", 32'(busy), 1);
    nxt();
    stop = 1'b0;
    smp();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_slow", 32'(slow_clk), 0);
    chk("t5_idle_tick", 32'(tick), 0);
    chk("t5_tcnt_hold", 32'(tick_count), 6);
    start = 1'b1;
    stop = 1'b1;
    nxt();
    start = 1'b0;
    stop = 1'b0;
    smp();
    chk("t5_startstop", 32'(busy), 0);
    nxt();
    cfg_valid = 1'b1;
    cfg_div = 27'd1;
    smp();
    chk("t3_ready", 32'(cfg_ready), 1);
    nxt();
    cfg_valid = 1'b0;
    smp();
    chk("t3_err", 32'(cfg_err), 1);
    chk("t3_ready_after", 32'(cfg_ready), 1);
    chk("t3_busy", 32'(busy), 0);
    nxt();
    smp();
    chk("t3_err_clear", 32'(cfg_err), 0);
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      smp();
      chk($sformatf("t3_div_kept_c%0d", c), 32'(tick), 32'(c == 6));
      nxt();
    end
    stop = 1'b1;
    nxt();
    stop = 1'b0;
    smp();
    chk("t3_stop_busy", 32'(busy), 0);
    chk("t3_tcnt", 32'(tick_count), 1);
    cfg_valid = 1'b1;
    cfg_div = 27'd5;
    cfg_oneshot = 1'b1;
    start = 1'b1;
    nxt();
    cfg_valid = 1'b0;
    cfg_oneshot = 1'b0;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      smp();
      chk($sformatf("t4_tick_c%0d", c), 32'(tick), 32'(c == 5));
      chk($sformatf("t4_busy_c%0d", c), 32'(busy), 32'(c <= 5));
      chk($sformatf("t4_slow_c%0d", c), 32'(slow_clk), 32'(c >= 3 && c <= 5));
      nxt();
    end
    smp();
    chk("t4_tcnt", 32'(tick_count), 1);
    nxt();
    cfg_valid = 1'b1;
    cfg_div = 27'd8;
    cfg_oneshot = 1'b0;
    nxt();
    cfg_valid = 1'b0;
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    cfg_valid = 1'b1;
    cfg_div = 27'd3;
    nxt();
    cfg_valid = 1'b0;
    smp();
    chk("t6_pend_ready", 32'(cfg_ready), 0);
    chk("t6_pend_busy", 32'(busy), 1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    chk("t6_rst_ready", 32'(cfg_ready), 1);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    chk("t6_rst_slow", 32'(slow_clk), 0);
    chk("t6_rst_tcnt", 32'(tick_count), 0);
    chk("t6_rst_err", 32'(cfg_err), 0);
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      smp();
      chk($sformatf("t6_default_tick_c%0d", c), 32'(tick), 32'(c == 4 || c == 8));
      nxt();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
